// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter: owns the register file's single write port and
// merges results from two producers. ALU results cannot be stalled and always
// win. Load results arrive by valid/ready handshake and wait in an in-order
// FIFO until the port is free. The pending mask tells the issue stage which
// registers still have a queued load write.
module reg_writeback_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int SEL_WIDTH  = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int NUM_REGS   = 2 ** SEL_WIDTH,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [SEL_WIDTH-1:0]  alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [SEL_WIDTH-1:0]  mem_sel,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  write_en,
  output logic [SEL_WIDTH-1:0]  write_sel,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  collide_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Load-result storage. Contents need no reset: validity comes from the
  // pointers and count alone, so a reset empties the queue immediately.
  logic [SEL_WIDTH-1:0]  sel_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]      count_reg,  count_next;

  logic                  write_en_reg,   write_en_next;
  logic [SEL_WIDTH-1:0]  write_sel_reg,  write_sel_next;
  logic [DATA_WIDTH-1:0] write_data_reg, write_data_next;
  logic                  collide_reg,    collide_next;

  logic                  alu_take;
  logic                  enq;
  logic                  deq;
  logic [NUM_REGS-1:0]   entry_mask [FIFO_DEPTH];
  logic [NUM_REGS-1:0]   pending_comb;

  // Ready depends only on stored occupancy, never on a same-cycle dequeue.
  assign mem_ready = (count_reg < CNT_W'(FIFO_DEPTH));
  assign alu_take  = alu_valid && (alu_sel != '0);
  // Register 0 is hardwired zero: such loads complete the handshake but are
  // not stored.
  assign enq       = mem_valid && mem_ready && (mem_sel != '0);
  assign deq       = !alu_take && (count_reg != '0);

  // Each storage slot contributes one-hot(sel) only while it lies inside the
  // occupied window starting at the read pointer.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic [PTR_W-1:0] offset;
    assign offset         = PTR_W'(gi) - rd_ptr_reg;
    assign entry_mask[gi] = (CNT_W'(offset) < count_reg)
                            ? (NUM_REGS'(1) << sel_mem[gi]) : '0;
  end

  // OR the per-slot masks into the exported pending-write mask.
  always_comb begin
    pending_comb = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pending_comb = pending_comb | entry_mask[i];
    end
  end

  // Store an accepted load at the write pointer.
  always_ff @(posedge clk) begin
    if (enq) begin
      sel_mem[wr_ptr_reg]  <= mem_sel;
      data_mem[wr_ptr_reg] <= mem_data;
    end
  end

  // Next-state: output priority (ALU, then FIFO head, then idle hold),
  // pointer/count bookkeeping and the sticky collision flag.
  always_comb begin
    write_en_next   = 1'b0;
    write_sel_next  = write_sel_reg;
    write_data_next = write_data_reg;
    rd_ptr_next     = rd_ptr_reg;
    wr_ptr_next     = wr_ptr_reg;
    count_next      = count_reg;
    collide_next    = collide_reg;

    if (alu_take) begin
      write_en_next   = 1'b1;
      write_sel_next  = alu_sel;
      write_data_next = alu_data;
    end else if (deq) begin
      write_en_next   = 1'b1;
      write_sel_next  = sel_mem[rd_ptr_reg];
      write_data_next = data_mem[rd_ptr_reg];
    end

    if (enq) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (deq) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    if (enq && !deq) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!enq && deq) begin
      count_next = count_reg - CNT_W'(1);
    end

    // An ALU write to a register with a queued load means issue let a
    // hazard through; both writes still go out, ALU first.
    if (alu_take && pending_comb[alu_sel]) begin
      collide_next = 1'b1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_reg   <= 1'b0;
      write_sel_reg  <= '0;
      write_data_reg <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      collide_reg    <= 1'b0;
    end else begin
      write_en_reg   <= write_en_next;
      write_sel_reg  <= write_sel_next;
      write_data_reg <= write_data_next;
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      collide_reg    <= collide_next;
    end
  end

  assign write_en     = write_en_reg;
  assign write_sel    = write_sel_reg;
  assign write_data   = write_data_reg;
  assign pending_mask = pending_comb;
  assign fifo_count   = count_reg;
  assign collide_err  = collide_reg;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed testbench for reg_writeback_arbiter: hand-computed expectations
// for reset, ALU writes, load/ALU contention, FIFO fill and wrap, register 0,
// collision detection and asynchronous reset mid-operation.
module tb_reg_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_sel = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_data = '0;
  logic        write_en;
  logic [3:0]  write_sel;
  logic [31:0] write_data;
  logic [15:0] pending_mask;
  logic [2:0]  fifo_count;
  logic        collide_err;

  int errors = 0;
  int checks = 0;

  reg_writeback_arbiter #(
    .DATA_WIDTH(32),
    .SEL_WIDTH (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_sel     (alu_sel),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_sel     (mem_sel),
    .mem_data    (mem_data),
    .write_en    (write_en),
    .write_sel   (write_sel),
    .write_data  (write_data),
    .pending_mask(pending_mask),
    .fifo_count  (fifo_count),
    .collide_err (collide_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_sel   = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_sel   = '0;
    mem_data  = '0;
  endtask

  initial begin
    int idx;
    int got_n;
    logic accepted;

    // ---------------- reset state ----------------
    #2;
    check("rst_write_en",   write_en,     0);
    check("rst_write_sel",  write_sel,    0);
    check("rst_write_data", write_data,   0);
    check("rst_fifo_count", fifo_count,   0);
    check("rst_pending",    pending_mask, 0);
    check("rst_collide",    collide_err,  0);
    check("rst_mem_ready",  mem_ready,    1);
    tick();
    rst_n = 1'b1;
    tick();

    // ---------------- ALU only ----------------
    alu_valid = 1'b1; alu_sel = 4'd3; alu_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    check("alu_we",   write_en,   1);
    check("alu_sel",  write_sel,  3);
    check("alu_data", write_data, 32'hDEADBEEF);
    tick();
    check("alu_we_off", write_en, 0);

    // ---------------- load with ALU contention ----------------
    mem_valid = 1'b1; mem_sel = 4'd5; mem_data = 32'h11;       // cycle 0
    check("cont_ready", mem_ready, 1);
    tick();
    idle_inputs();
    alu_valid = 1'b1; alu_sel = 4'd2; alu_data = 32'hA0;        // cycle 1
    check("cont_pm_c1",  pending_mask, 16'h0020);
    check("cont_cnt_c1", fifo_count,   1);
    tick();
    alu_data = 32'hA1;                                          // cycle 2
    check("cont_we_c2",   write_en,     1);
    check("cont_sel_c2",  write_sel,    2);
    check("cont_data_c2", write_data,   32'hA0);
    check("cont_pm_c2",   pending_mask, 16'h0020);
    tick();
    idle_inputs();                                              // cycle 3
    check("cont_sel_c3",  write_sel,    2);
    check("cont_data_c3", write_data,   32'hA1);
    check("cont_pm_c3",   pending_mask, 16'h0020);
    tick();                                                     // cycle 4
    check("cont_we_c4",   write_en,     1);
    check("cont_sel_c4",  write_sel,    5);
    check("cont_data_c4", write_data,   32'h11);
    check("cont_pm_c4",   pending_mask, 0);
    check("cont_cnt_c4",  fifo_count,   0);
    tick();
    check("cont_we_c5", write_en, 0);

    // ---------------- fill and ordering ----------------
    // ALU writes r9 for 4 cycles so loads 1..4 pile up, then drain.
    idx = 1;
    got_n = 0;
    for (int c = 0; c < 30; c++) begin
      alu_valid = (c < 4);
      alu_sel   = 4'd9;
      alu_data  = 32'(c);
      mem_valid = (idx <= 6);
      mem_sel   = 4'(idx);
      mem_data  = 32'h100 + 32'(idx);
      if (c == 4) begin
        check("fill_full_cnt",   fifo_count, 4);
        check("fill_full_ready", mem_ready,  0);
      end
      accepted = mem_valid && mem_ready;
      tick();
      if (accepted) idx++;
      if (fifo_count > 3'd4) check("fill_cnt_le4", fifo_count, 4);
      if (write_en && write_sel != 4'd9) begin
        check("fill_order_sel",  write_sel,  got_n + 1);
        check("fill_order_data", write_data, 32'h100 + 32'(got_n + 1));
        got_n++;
      end
    end
    idle_inputs();
    check("fill_all_accepted", idx,        7);
    check("fill_all_written",  got_n,      6);
    check("fill_empty",        fifo_count, 0);

    // ---------------- register zero ----------------
    mem_valid = 1'b1; mem_sel = 4'd0; mem_data = 32'h55;
    alu_valid = 1'b1; alu_sel = 4'd0; alu_data = 32'h66;
    check("r0_ready", mem_ready, 1);
    tick();
    idle_inputs();
    check("r0_we",  write_en,   0);
    check("r0_cnt", fifo_count, 0);
    tick();
    check("r0_we2", write_en, 0);

    // ---------------- collision ----------------
    mem_valid = 1'b1; mem_sel = 4'd7; mem_data = 32'h77;
    tick();
    idle_inputs();
    alu_valid = 1'b1; alu_sel = 4'd7; alu_data = 32'hA7;
    check("col_pm",     pending_mask, 16'h0080);
    check("col_before", collide_err,  0);
    tick();
    idle_inputs();
    check("col_flag",     collide_err, 1);
    check("col_alu_sel",  write_sel,   7);
    check("col_alu_data", write_data,  32'hA7);
    tick();
    check("col_ld_we",   write_en,    1);
    check("col_ld_sel",  write_sel,   7);
    check("col_ld_data", write_data,  32'h77);
    check("col_sticky",  collide_err, 1);
    tick();
    check("col_sticky2", collide_err, 1);
    check("col_we_off",  write_en,    0);

    // ---------------- reset mid-operation ----------------
    for (int k = 1; k <= 3; k++) begin
      alu_valid = 1'b1; alu_sel = 4'd9; alu_data = 32'h900;
      mem_valid = 1'b1; mem_sel = 4'(k); mem_data = 32'h300 + 32'(k);
      tick();
    end
    idle_inputs();
    check("rm_cnt_pre", fifo_count,   3);
    check("rm_pm_pre",  pending_mask, 16'h000E);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_cnt",     fifo_count,   0);
    check("rm_pm",      pending_mask, 0);
    check("rm_we",      write_en,     0);
    check("rm_collide", collide_err,  0);
    check("rm_ready",   mem_ready,    1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (write_en !== 1'b0) check("rm_no_stale", write_en, 0);
    end
    check("rm_cnt_post", fifo_count, 0);
    check("rm_we_post",  write_en,   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound so the bench always ends on its own.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
